// File: rtl/spi_sram_23lc512.sv
// rtl/spi_sram_23lc512.sv - SPI mode-0 slave model of a 23LC512 64 KB serial SRAM
module spi_sram_23lc512 #(
   parameter int ADDR_W    = 16,
   parameter int PAGE_SIZE = 32
) (
   input  logic SCK,
   input  logic RESET,
   input  logic CS_N,
   input  logic SI_SIO0,
   output logic SO_SIO1,
   input  logic HOLD_N_SIO3
);

   localparam logic [7:0]        OP_READ   = 8'h03;
   localparam logic [7:0]        OP_WRITE  = 8'h02;
   localparam logic [7:0]        OP_RDMR   = 8'h05;
   localparam logic [7:0]        OP_WRMR   = 8'h01;
   localparam logic [1:0]        MODE_BYTE = 2'b00;
   localparam logic [1:0]        MODE_PAGE = 2'b10;
   localparam logic [1:0]        MODE_SEQ  = 2'b01;
   localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_SIZE - 1);
   localparam logic [4:0]        ADDR_LAST = 5'(ADDR_W - 1);

   typedef enum logic [2:0] {
      PH_CMD, PH_RADDR, PH_WADDR, PH_WDATA, PH_RDATA, PH_RDMR, PH_WRMR, PH_IGNORE
   } phase_t;

   phase_t            phase, phase_nx;
   logic [4:0]        bit_cnt;
   logic [ADDR_W-2:0] sr;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        out_byte;
   logic [2:0]        out_idx;
   logic              wr_done;
   logic [1:0]        mode;
   logic              so_en, so_bit;
   logic [7:0]        mem [0:(2**ADDR_W)-1];

   logic              active, byte_end, addr_end;
   logic [7:0]        byte_val;
   logic [ADDR_W-1:0] addr_val, addr_inc, addr_adv, rd_addr;
   logic              field_end, addr_load, addr_step, mem_we, mode_we;
   logic              load_mem, load_mode, drive;

   // HOLD low freezes the transaction: every SCK edge is ignored while it is low
   assign active   = HOLD_N_SIO3;
   assign byte_end = (bit_cnt == 5'd7);
   assign addr_end = (bit_cnt == ADDR_LAST);
   assign byte_val = {sr[6:0], SI_SIO0};
   assign addr_val = {sr, SI_SIO0};
   assign addr_inc = addr + ADDR_W'(1);
   // page mode keeps the page bits and wraps the offset; otherwise a plain increment
   assign addr_adv = (mode == MODE_PAGE) ? ((addr & ~PAGE_MASK) | (addr_inc & PAGE_MASK))
                                         : addr_inc;

   // phase register: cleared immediately by CS_N high, synchronously by RESET
   always_ff @(posedge SCK or posedge CS_N) begin
      if (CS_N)
         phase <= PH_CMD;
      else if (RESET)
         phase <= PH_CMD;
      else if (active)
         phase <= phase_nx;
   end

   // next phase from the current field and the decoded opcode
   always_comb begin
      phase_nx = phase;
      case (phase)
         PH_CMD: begin
            if (byte_end) begin
               case (byte_val)
                  OP_READ:  phase_nx = PH_RADDR;
                  OP_WRITE: phase_nx = PH_WADDR;
                  OP_RDMR:  phase_nx = PH_RDMR;
                  OP_WRMR:  phase_nx = PH_WRMR;
                  default:  phase_nx = PH_IGNORE;
               endcase
            end
         end
         PH_RADDR: if (addr_end) phase_nx = PH_RDATA;
         PH_WADDR: if (addr_end) phase_nx = PH_WDATA;
         PH_RDATA: if (out_idx == 3'd0 && mode == MODE_BYTE) phase_nx = PH_IGNORE;
         PH_WRMR:  if (byte_end) phase_nx = PH_IGNORE;
         default:  phase_nx = phase;
      endcase
   end

   // per-phase strobes for the datapath, array and mode register
   always_comb begin
      field_end = 1'b0;
      addr_load = 1'b0;
      addr_step = 1'b0;
      mem_we    = 1'b0;
      mode_we   = 1'b0;
      load_mem  = 1'b0;
      load_mode = 1'b0;
      drive     = 1'b0;
      rd_addr   = addr_val;
      case (phase)
         PH_CMD: begin
            field_end = byte_end;
            load_mode = byte_end && (byte_val == OP_RDMR);
         end
         PH_RADDR: begin
            field_end = addr_end;
            addr_load = addr_end;
            load_mem  = addr_end;
         end
         PH_WADDR: begin
            field_end = addr_end;
            addr_load = addr_end;
         end
         PH_WDATA: begin
            field_end = byte_end;
            mem_we    = byte_end && !(mode == MODE_BYTE && wr_done);
            addr_step = mem_we;
         end
         PH_RDATA: begin
            drive     = 1'b1;
            load_mem  = (out_idx == 3'd0) && (mode != MODE_BYTE);
            addr_step = load_mem;
            rd_addr   = addr_adv;
         end
         PH_RDMR: begin
            drive     = 1'b1;
            load_mode = (out_idx == 3'd0);
         end
         PH_WRMR: begin
            field_end = byte_end;
            mode_we   = byte_end && (byte_val[7:6] != 2'b11);
         end
         default: ;
      endcase
      if (!active || RESET) begin
         mem_we  = 1'b0;
         mode_we = 1'b0;
      end
   end

   // transaction datapath: shift-in, bit counter, address and output byte
   always_ff @(posedge SCK or posedge CS_N) begin
      if (CS_N || RESET) begin
         bit_cnt  <= 5'd0;
         sr       <= '0;
         addr     <= '0;
         out_byte <= 8'h00;
         out_idx  <= 3'd0;
         wr_done  <= 1'b0;
      end else if (active) begin
         bit_cnt <= field_end ? 5'd0 : bit_cnt + 5'd1;
         sr      <= addr_val[ADDR_W-2:0];
         if (addr_load)
            addr <= addr_val;
         else if (addr_step)
            addr <= addr_adv;
         if (mem_we)
            wr_done <= 1'b1;
         if (load_mem) begin
            out_byte <= mem[rd_addr];
            out_idx  <= 3'd7;
         end else if (load_mode) begin
            out_byte <= {mode, 6'b000000};
            out_idx  <= 3'd7;
         end else if (drive) begin
            out_idx <= out_idx - 3'd1;
         end
      end
   end

   // mode register survives CS_N; only RESET or a valid WRMR changes it
   always_ff @(posedge SCK) begin
      if (RESET)
         mode <= MODE_SEQ;
      else if (mode_we)
         mode <= byte_val[7:6];
   end

   // array write on the rising edge that completes a data byte
   always_ff @(posedge SCK) begin
      if (mem_we)
         mem[addr] <= byte_val;
   end

   // output bit launched on the falling edge so the master samples it on the next rise
   always_ff @(negedge SCK or posedge CS_N) begin
      if (CS_N) begin
         so_en  <= 1'b0;
         so_bit <= 1'b0;
      end else if (active) begin
         so_en  <= drive;
         so_bit <= out_byte[out_idx];
      end
   end

   assign SO_SIO1 = (so_en && active && !CS_N) ? so_bit : 1'bz;

endmodule

// File: tb/tb_spi_sram_23lc512.sv
// tb/tb_spi_sram_23lc512.sv - directed and randomized bench for spi_sram_23lc512
module tb_spi_sram_23lc512;

   localparam int PAGE = 32;
   localparam int MEMSZ = 65536;
   localparam logic [7:0] HIZ = 8'hFF;   // released SO reads as 1 through the pull-up

   logic sck, reset, cs_n, si, hold_n;
   wire  so;
   pullup (so);

   int checks = 0;
   int errors = 0;

   logic [7:0] ref_mem [0:MEMSZ-1];
   logic [1:0] ref_mode;

   spi_sram_23lc512 #(.ADDR_W(16), .PAGE_SIZE(PAGE)) dut (
      .SCK(sck), .RESET(reset), .CS_N(cs_n), .SI_SIO0(si),
      .SO_SIO1(so), .HOLD_N_SIO3(hold_n)
   );

   initial sck = 1'b0;
   always #5 sck = ~sck;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int next_addr(input int a);
      if (ref_mode == 2'b10)
         return (a / PAGE) * PAGE + ((a % PAGE) + 1) % PAGE;
      return (a + 1) % MEMSZ;
   endfunction

   // one bit period, entered and left just after a falling edge
   task automatic step(input logic b, output logic s);
      si = b;
      @(posedge sck);
      #1 s = so;
      @(negedge sck);
      #1;
   endtask

   task automatic send(input logic [31:0] v, input int n);
      logic s;
      for (int i = n - 1; i >= 0; i--) step(v[i], s);
   endtask

   task automatic recv(output logic [7:0] v);
      logic s;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, s);
         v = {v[6:0], s};
      end
   endtask

   task automatic begin_cs();
      @(negedge sck);
      #1 cs_n = 1'b0;
   endtask

   task automatic end_cs();
      cs_n = 1'b1;
      si   = 1'b0;
      @(negedge sck);
      #1;
   endtask

   task automatic wrmr(input logic [7:0] v);
      begin_cs();
      send(32'h01, 8);
      send(32'(v), 8);
      end_cs();
      if (v[7:6] != 2'b11) ref_mode = v[7:6];
   endtask

   task automatic rdmr(input string tag);
      logic [7:0] got;
      begin_cs();
      send(32'h05, 8);
      for (int i = 0; i < 2; i++) begin
         recv(got);
         check(tag, got, {ref_mode, 6'b000000});
      end
      end_cs();
   endtask

   task automatic do_write(input int a, input logic [31:0] d, input int n);
      int cur = a;
      begin_cs();
      send(32'h02, 8);
      send(32'(a), 16);
      send(d, 8 * n);
      end_cs();
      for (int i = 0; i < n; i++) begin
         if (ref_mode == 2'b00 && i > 0) break;
         ref_mem[cur] = d[8 * (n - 1 - i) +: 8];
         cur = next_addr(cur);
      end
   endtask

   task automatic do_read(input string tag, input int a, input int n);
      logic [7:0] got;
      int cur = a;
      begin_cs();
      send(32'h03, 8);
      send(32'(a), 16);
      for (int i = 0; i < n; i++) begin
         recv(got);
         if (ref_mode == 2'b00 && i > 0) begin
            check(tag, got, HIZ);
         end else begin
            check(tag, got, ref_mem[cur]);
            cur = next_addr(cur);
         end
      end
      end_cs();
   endtask

   initial begin
      logic [7:0] m;
      int a, n;
      logic [31:0] d;

      reset = 1'b1; cs_n = 1'b1; si = 1'b0; hold_n = 1'b1;
      ref_mode = 2'b01;
      repeat (3) @(negedge sck);
      #1 reset = 1'b0;
      @(negedge sck);
      #1;
      check("reset_so_hiz", {7'd0, so}, 8'd1);
      rdmr("reset_mode");

      // sequential mode
      do_write(16'h1234, 32'hAA55C3, 3);
      do_read("seq_read3", 16'h1234, 3);
      do_read("seq_read_off", 16'h1235, 1);

      // sequential wrap at the top of the array
      do_write(16'hFFFF, 32'h1122, 2);
      do_read("wrap_ffff", 16'hFFFF, 1);
      do_read("wrap_0000", 16'h0000, 1);
      do_read("wrap_stream", 16'hFFFF, 2);

      // page mode wraps within the 32-byte page
      do_write(16'h0040, 32'h5A, 1);
      wrmr(8'h80);
      rdmr("page_mode_reg");
      do_write(16'h003F, 32'h0102, 2);
      do_read("page_003f", 16'h003F, 1);
      do_read("page_0020", 16'h0020, 1);
      do_read("page_0040", 16'h0040, 1);
      do_read("page_stream", 16'h003F, 3);

      // byte mode: one byte written, one byte read then SO released
      wrmr(8'h40);
      do_write(16'h0011, 32'h77, 1);
      wrmr(8'h00);
      rdmr("byte_mode_reg");
      do_write(16'h0010, 32'h9ABC, 2);
      do_read("byte_read2", 16'h0010, 2);
      do_read("byte_0011", 16'h0011, 1);

      // reserved mode 11 leaves the register alone
      wrmr(8'hC0);
      rdmr("mode11_ignored");

      // unknown opcode: SO stays released for the whole transaction
      begin_cs();
      send(32'h9F, 8);
      recv(m);
      check("bad_opcode_hiz", m, HIZ);
      end_cs();

      // CS_N abort after 12 address bits of a WRITE
      begin_cs();
      send(32'h02, 8);
      send(32'h123, 12);
      end_cs();
      do_read("abort_read", 16'h1234, 1);

      // reset mid-WRITE: committed byte kept, partial byte lost, mode back to 0x40
      wrmr(8'h80);
      begin_cs();
      send(32'h02, 8);
      send(32'h2000, 16);
      send(32'h33, 8);
      send(32'h5, 4);
      reset = 1'b1;
      send(32'h0, 2);
      reset = 1'b0;
      end_cs();
      ref_mem[16'h2000] = 8'h33;
      ref_mode = 2'b01;
      rdmr("reset_mid_write_mode");
      do_read("reset_committed", 16'h2000, 1);

      // randomized mode / address / length against the model
      for (int it = 0; it < 20; it++) begin
         m = {2'($urandom_range(0, 3)), 6'b000000};
         wrmr(m);
         rdmr("rand_mode");
         a = int'($urandom_range(0, MEMSZ - 1));
         n = int'($urandom_range(1, 4));
         d = $urandom;
         do_write(a, d, n);
         do_read("rand_read", a, n);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_sram_23lc512.md
# spi_sram_23lc512

SPI-slave behavioural/RTL model of a 64 KB serial SRAM (23LC512 command set, single-bit SPI mode 0). It sits on the SoC testbench board attached to SPI0 and gives the SPI master real read/write targets. The block decodes READ, WRITE, RDMR and WRMR. It holds the byte/page/sequential mode register and the 64K × 8 array.

## Interface
- `ADDR_W`, 16: address width; the array holds 2^ADDR_W bytes.
- `PAGE_SIZE`, 32: page length in bytes for page mode; must be a power of two.
- `SCK` in 1: SPI clock and the only clock. Inputs are sampled on the rising edge; SO changes on the falling edge.
- `RESET` in 1: synchronous, active-high reset, sampled on the `SCK` rising edge.
- `CS_N` in 1: chip select, active-low; delimits one transaction.
- `SI_SIO0` in 1: serial data in, MSB first.
- `SO_SIO1` out 1: serial data out, tri-state; high-Z whenever not in a data-output phase.
- `HOLD_N_SIO3` in 1: hold, active-low; the board ties it high.

## Operation
- Transaction: 8-bit instruction, then the fields listed below, all MSB first.
- Opcodes:
  - 0x03 READ: 16-bit address, then data is output.
  - 0x02 WRITE: 16-bit address, then data is input.
  - 0x05 RDMR: the mode register is output.
  - 0x01 WRMR: one data byte is input.
- Any other opcode: ignored. SO stays high-Z and SCK is ignored until `CS_N` goes high.
- Mode register MODE[7:6]:
  - 00 = byte mode.
  - 10 = page mode.
  - 01 = sequential mode; this is the reset value, so the register resets to 0x40.
  - Bits [5:0] always read 0.
  - A WRMR with bits [7:6]=11 leaves the register unchanged.
- WRITE: each completed data byte is written to mem[addr] on its 8th rising edge.
  - Sequential mode: addr increments by 1, and 0xFFFF wraps to 0x0000.
  - Page mode: addr[4:0] increments and wraps within the page; addr[15:5] is held.
  - Byte mode: only the first data byte is written; later bytes are ignored.
  - A partial byte (fewer than 8 bits before `CS_N` rises) is discarded.
- READ: the data byte at addr is shifted out. The address advances per byte using the same rules as WRITE.
  - Byte mode: after one byte, SO goes high-Z for the rest of the transaction.
- RDMR: outputs the mode register repeatedly for as long as clocks continue.
- WRMR: the register updates on the 16th rising edge. Further bits are ignored.
- `CS_N` high clears the transaction state (bit counter, phase, SO enable) and forces SO high-Z.
  - This clear is asynchronous; it is the only async path.
  - The mode register and the array are unaffected.
- `HOLD_N_SIO3` low: SCK edges are ignored and SO is high-Z. The transaction resumes when it returns high.
- `RESET` clears: phase = idle, mode = 0x40, SO high-Z. The array contents are not cleared.
- The array is uninitialised (reads X) until written.

## Timing
- Instruction: rising edges 1–8. Address: rising edges 9–24.
- READ: data bit 7 is driven on the falling edge after rising edge 24. Each following bit is driven on the next falling edge.
  - The next byte's MSB follows the previous LSB with no gap.
- The read address for byte n+1 is fetched before its MSB falling edge, so back-to-back bytes stream continuously.
- RDMR: bit 7 is driven on the falling edge after rising edge 8.
- SO goes high-Z within 0 cycles of `CS_N` rising (combinational).
- Reset during a transaction aborts it. A write byte already committed stays written; a partial byte is lost.
- Array write and RDMR/WRMR register update both occur on the sampling rising edge itself. The next READ in the same or a later transaction returns the new data.

## Test plan
- After `RESET`, RDMR -> SO shifts 0x40 (0100_0000).
- Sequential mode: WRITE 0x1234 with data AA, 55, C3 -> a READ at 0x1234 of 3 bytes returns AA, 55, C3. A READ at 0x1235 returns 55.
- Sequential wrap: WRITE 0xFFFF with 11, 22 -> mem[0xFFFF]=11, mem[0x0000]=22.
- WRMR 0x80 (page mode): WRITE 0x003F with 01, 02 -> mem[0x003F]=01, mem[0x0020]=02, and 0x0040 is unchanged.
- WRMR 0x00 (byte mode): WRITE 0x0010 with 9A, BC -> mem[0x0010]=9A, 0x0011 is unchanged. A 2-byte READ returns 9A, then SO is high-Z.
- Raise `CS_N` after 12 address bits of a WRITE, then do a full READ of 0x1234 -> the read returns AA and no memory changes. `RESET` asserted mid-WRITE -> RDMR returns 0x40.
